residual_out_buf: RTL
=====================

# residual_out_buf

Parametrised multi-bank macroblock residual buffer between the transform stage and reconstruction in the H.264 decoder. The transform stage writes one 4x4 block of residuals (16 samples) per beat. Completed macroblocks are queued in a ring of banks, so transform of MB n+1 overlaps reconstruction of MB n. An intra bypass path presents write data directly on the read port. Blocks the CAVLC stage skipped can read back as zero without being written.

## Interface
Parameters:
- RES_W, 9: signed residual sample width.
- BLK_AW, 5: block-index address width; 2^BLK_AW blocks per bank (24 used: 16 luma + 8 chroma).
- NUM_BANK, 2: macroblock banks, power of two, ≥2.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-high.
- bypass  in  1  1 = intra: rd_data mirrors wr_data combinationally; no RAM write.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write bank accepting.
- wr_blk_idx  in  BLK_AW  target block.
- wr_data  in  16*RES_W  samples 0..15, sample 0 in MSBs.
- wr_mb_done  in  1  pulse: close current write bank.
- rd_mb_avail  out  1  oldest bank closed and readable.
- rd_en  in  1  read request.
- rd_blk_idx  in  BLK_AW  block to read.
- rd_data  out  16*RES_W  read data, 1 cycle after rd_en.
- rd_valid  out  1  rd_data qualifier.
- rd_mb_done  in  1  pulse: release oldest bank.
- mb_count  out  $clog2(NUM_BANK)+1  closed banks pending.
- err  out  1  sticky protocol error.

## Operation
- Each bank has a state: EMPTY → FILLING on the first accepted write. FILLING → FULL on wr_mb_done. FULL → EMPTY on rd_mb_done.
- wr_mb_done on an EMPTY bank also moves it to FULL, giving an all-skipped MB.
- Write and read pointers each advance modulo NUM_BANK when their bank closes or is released.
- RAM address is {bank_ptr, blk_idx}; depth NUM_BANK·2^BLK_AW.
- wr_ready = (write bank ≠ FULL) and !bypass.
- A write occurs on wr_valid & wr_ready.
- wr_valid and wr_mb_done in the same cycle: the beat is written to the current bank first, then the bank closes.
- wr_mb_done while the write bank is FULL: ignored, err set.
- rd_mb_avail = read bank FULL.
- rd_en while !rd_mb_avail and !bypass: no read; rd_valid stays 0; err set.
- rd_mb_done while !rd_mb_avail: ignored, err set.
- wr_mb_done and rd_mb_done in the same cycle act on their respective banks. mb_count is unchanged in that cycle.
- bypass=1: rd_data = wr_data and rd_valid = wr_valid, both combinational. Bank state is frozen.
- Samples pass through unmodified; there is no arithmetic on data.

## Timing
- Reset values: wr_ready=1, rd_mb_avail=0, rd_valid=0, rd_data=0, mb_count=0, err=0. All banks EMPTY, both pointers 0, bitmaps cleared.
- Write-to-readable latency: 1 cycle after wr_mb_done.
- Read latency: 1 cycle (registered RAM output). Back-to-back reads sustain 1 block/cycle.
- rd_mb_done releases the bank at the clock edge. A read issued in the same cycle still returns that bank's data.
- Reset mid-MB discards all banks. RAM contents are not cleared; the bitmaps mask them.

## Configuration
- RESIDUAL_BUF_ZERO_FILL_EN defined: each bank keeps a 2^BLK_AW written-bitmap, set on write and cleared on release. A read of an unwritten block returns all zeros.
- Undefined: no bitmap. Unwritten blocks return stale RAM contents, and the producer must write every block it expects back.

## Structure
- Shared package holds: bank state encoding (EMPTY, FILLING, FULL); the RES_W and BLK_AW defaults; the packing macro for the 16-sample bus.
- One sub-module, residual_buf_ram: simple dual-port, registered read, one clock, no reset on the array.
- Control FSM, pointers, bitmaps and bypass mux live in residual_out_buf.

## Test plan
- Reset, then write blk 3 with samples 1..16, wr_mb_done, rd_en blk 3 → next cycle rd_valid=1, rd_data=1..16; mb_count=1.
- With ZERO_FILL_EN: read unwritten blk 7 of a closed bank → rd_data all 0. Without the macro → prior RAM contents.
- NUM_BANK=2: close two MBs without reading → wr_ready=0, mb_count=2. rd_mb_done → wr_ready=1 next cycle, mb_count=1.
- Same cycle: wr_mb_done and rd_mb_done with mb_count=1 → mb_count stays 1 and both pointers advance.
- bypass=1 with wr_valid and wr_data=0x1FF in every sample → rd_data=0x1FF… and rd_valid=1 in the same cycle. No bank changes state.
- rd_mb_done with no closed bank → err=1 and stays 1 until reset. Assert rst mid-fill → all outputs at reset values immediately.

Source files
------------

// File: rtl/residual_out_buf_pkg.sv
// Shared definitions for the residual output buffer: bank state encoding,
// default geometry, and the 16-sample bus slicing macro.
`ifndef RESIDUAL_OUT_BUF_PKG_SV
`define RESIDUAL_OUT_BUF_PKG_SV

// Select sample i (0..15) of a packed 16-sample bus; sample 0 lives in the MSBs.
`define RESBUF_SAMPLE(bus, i, w) bus[(15-(i))*(w) +: (w)]

package residual_out_buf_pkg;

  localparam int RES_W_DEF       = 9;
  localparam int BLK_AW_DEF      = 5;
  localparam int SAMPLES_PER_BLK = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

endpackage

`endif

// File: rtl/residual_out_buf_if.sv
// Bus bundle between transform (master) and the residual buffer (slave).
//
// Handshake semantics: a write beat transfers on a clock edge where
// wr_valid && wr_ready are both high; wr_valid must not depend on wr_ready.
// Reads have no backpressure: rd_en is a request, and rd_valid qualifies
// rd_data exactly one cycle later (combinationally when bypass=1).
// wr_mb_done / rd_mb_done are single-cycle pulses sampled at the clock edge.
interface residual_out_buf_if #(
  parameter int RES_W    = residual_out_buf_pkg::RES_W_DEF,
  parameter int BLK_AW   = residual_out_buf_pkg::BLK_AW_DEF,
  parameter int NUM_BANK = 2
);
  localparam int DW = 16 * RES_W;
  localparam int CW = $clog2(NUM_BANK) + 1;

  logic              bypass;
  logic              wr_valid;
  logic              wr_ready;
  logic [BLK_AW-1:0] wr_blk_idx;
  logic [DW-1:0]     wr_data;
  logic              wr_mb_done;
  logic              rd_mb_avail;
  logic              rd_en;
  logic [BLK_AW-1:0] rd_blk_idx;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              rd_mb_done;
  logic [CW-1:0]     mb_count;
  logic              err;
  // Packed bank states, bank b at [2*b +: 2], for observation only.
  logic [2*NUM_BANK-1:0] bank_st_dbg;

  modport slave (
    input  bypass, wr_valid, wr_blk_idx, wr_data, wr_mb_done,
           rd_en, rd_blk_idx, rd_mb_done,
    output wr_ready, rd_mb_avail, rd_data, rd_valid, mb_count, err, bank_st_dbg
  );

  modport master (
    output bypass, wr_valid, wr_blk_idx, wr_data, wr_mb_done,
           rd_en, rd_blk_idx, rd_mb_done,
    input  wr_ready, rd_mb_avail, rd_data, rd_valid, mb_count, err, bank_st_dbg
  );
endinterface

// File: rtl/residual_buf_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output, single clock. The array is deliberately not reset.
module residual_buf_ram #(
  parameter int DW = 144,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/residual_out_buf.sv
// Multi-bank macroblock residual buffer between transform and reconstruction.
// A ring of NUM_BANK banks lets the next MB fill while the previous one is
// read. bypass routes write data straight to the read port for intra MBs.
// Optional feature: define RESIDUAL_BUF_ZERO_FILL_EN to keep a per-bank
// written-bitmap so skipped (never written) blocks read back as zero.
module residual_out_buf
  import residual_out_buf_pkg::*;
#(
  parameter int RES_W    = RES_W_DEF,
  parameter int BLK_AW   = BLK_AW_DEF,
  parameter int NUM_BANK = 2
) (
  input logic               clk,
  input logic               rst,
  residual_out_buf_if.slave bus
);
  localparam int PW   = $clog2(NUM_BANK);
  localparam int CW   = PW + 1;
  localparam int NBLK = 1 << BLK_AW;
  localparam int DW   = SAMPLES_PER_BLK * RES_W;
  localparam int AW   = PW + BLK_AW;

  bank_state_t   bank_st [NUM_BANK];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] mb_count_q;
  logic          err_q;
  logic          rd_valid_q;
  logic          zero_q;
  logic [DW-1:0] ram_q;

  logic wr_bank_full;
  logic rd_bank_full;
  logic wr_fire;
  logic wr_close;
  logic rd_fire;
  logic rd_release;
  logic err_evt;

  // Handshake and event decode; bypass freezes all bank activity.
  always_comb begin
    wr_bank_full = (bank_st[wr_ptr] == BANK_FULL);
    rd_bank_full = (bank_st[rd_ptr] == BANK_FULL);
    wr_fire      = bus.wr_valid && !wr_bank_full && !bus.bypass;
    wr_close     = bus.wr_mb_done && !wr_bank_full && !bus.bypass;
    rd_fire      = bus.rd_en && rd_bank_full && !bus.bypass;
    rd_release   = bus.rd_mb_done && rd_bank_full && !bus.bypass;
    err_evt      = !bus.bypass &&
                   ((bus.wr_mb_done && wr_bank_full) ||
                    (bus.rd_en      && !rd_bank_full) ||
                    (bus.rd_mb_done && !rd_bank_full));
  end

  // Bank state machines, ring pointers, closed-bank count and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANK; b++) bank_st[b] <= BANK_EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mb_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wr_fire && bank_st[wr_ptr] == BANK_EMPTY) bank_st[wr_ptr] <= BANK_FILLING;
      // Closing overrides the fill transition so write+close lands as FULL.
      if (wr_close) begin
        bank_st[wr_ptr] <= BANK_FULL;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (rd_release) begin
        bank_st[rd_ptr] <= BANK_EMPTY;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({wr_close, rd_release})
        2'b10:   mb_count_q <= mb_count_q + 1'b1;
        2'b01:   mb_count_q <= mb_count_q - 1'b1;
        default: mb_count_q <= mb_count_q;
      endcase
      if (err_evt) err_q <= 1'b1;
    end
  end

  // Read qualifier, aligned with the RAM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_fire;
  end

`ifdef RESIDUAL_BUF_ZERO_FILL_EN
  logic [NBLK-1:0] written [NUM_BANK];

  // Written-bitmap: set on write, cleared on release; flags reads of skipped blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANK; b++) written[b] <= '0;
      zero_q <= 1'b0;
    end else begin
      if (wr_fire)    written[wr_ptr][bus.wr_blk_idx] <= 1'b1;
      if (rd_release) written[rd_ptr] <= '0;
      if (rd_fire)    zero_q <= !written[rd_ptr][bus.rd_blk_idx];
    end
  end
`else
  assign zero_q = 1'b0;
`endif

  residual_buf_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_ptr, bus.wr_blk_idx}),
    .wdata (bus.wr_data),
    .re    (rd_fire),
    .raddr ({rd_ptr, bus.rd_blk_idx}),
    .rdata (ram_q)
  );

  // Output mux: bypass mirrors write side; otherwise gated registered RAM data.
  always_comb begin
    bus.wr_ready    = !wr_bank_full && !bus.bypass;
    bus.rd_mb_avail = rd_bank_full;
    bus.mb_count    = mb_count_q;
    bus.err         = err_q;
    if (bus.bypass) begin
      bus.rd_data  = bus.wr_data;
      bus.rd_valid = bus.wr_valid;
    end else begin
      bus.rd_data  = (rd_valid_q && !zero_q) ? ram_q : '0;
      bus.rd_valid = rd_valid_q;
    end
    bus.bank_st_dbg = '0;
    for (int b = 0; b < NUM_BANK; b++) bus.bank_st_dbg[2*b +: 2] = bank_st[b];
  end
endmodule
